// File: rtl/tdc_therm_enc.sv
// Thermometer-to-binary encoder for a TDC delay line, with bubble
// correction, a 4-stage pipeline and a 4-entry output FIFO.
//
// Ports:
//   clk10m      : single clock, all logic on the rising edge
//   rst         : asynchronous active-high reset
//   smp_valid   : qualifies smp_taps for one cycle
//   smp_taps    : sampled thermometer vector, bit 0 = first tap
//   code_valid  : FIFO head is valid
//   code_ready  : consumer accepts the head word
//   code        : encoded tap count (0..TAPS)
//   code_bubble : residual bubble seen in the head word
//   drop_cnt    : saturating count of words lost to a full FIFO
module tdc_therm_enc #(
    parameter int TAPS   = 256,
    parameter int CODE_W = 9
) (
    input  logic              clk10m,
    input  logic              rst,
    input  logic              smp_valid,
    input  logic [TAPS-1:0]   smp_taps,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [CODE_W-1:0] code,
    output logic              code_bubble,
    output logic [7:0]        drop_cnt
);

    localparam int GROUPS = TAPS / 16;

    function automatic logic [4:0] pop16(
        input logic [15:0] x
    );
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(x[i]);
        end
        return n;
    endfunction

    logic              v1;
    logic              v2;
    logic              v3;
    logic [TAPS-1:0]   t_q;
    logic [TAPS-1:0]   c_q;
    logic [TAPS+1:0]   ext;
    logic [TAPS-1:0]   c_d;
    logic              bub_d;
    logic              bub_q;
    logic [4:0]        part_q [GROUPS];
    logic [CODE_W-1:0] sum;

    logic [CODE_W:0]   mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        cnt;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    // Virtual taps: t[-1]=1 below the line, t[TAPS]=0 above it.
    assign ext = {1'b0, t_q, 1'b1};

    // 3-input majority over each tap and its two neighbours.
    assign c_d = (ext[TAPS-1:0] & ext[TAPS:1])
               | (ext[TAPS:1]   & ext[TAPS+1:2])
               | (ext[TAPS-1:0] & ext[TAPS+1:2]);

    // A 0 followed by a 1 means correction could not fix it.
    assign bub_d = |(~c_q[TAPS-2:0] & c_q[TAPS-1:1]);

    always_ff @(posedge clk10m or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= smp_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_ff @(posedge clk10m) begin
        if (smp_valid) begin
            t_q <= smp_taps;
        end
        if (v1) begin
            c_q <= c_d;
        end
        if (v2) begin
            bub_q <= bub_d;
            for (int g = 0; g < GROUPS; g++) begin
                part_q[g] <= pop16(c_q[g*16 +: 16]);
            end
        end
    end

    // Final adder; its result is registered by the FIFO write.
    always_comb begin
        sum = '0;
        for (int g = 0; g < GROUPS; g++) begin
            sum = sum + CODE_W'(part_q[g]);
        end
    end

    assign full    = (cnt == 3'd4);
    assign pop     = code_valid & code_ready;
    // A pop in the same cycle frees the slot for the push.
    assign push_ok = v3 & (~full | pop);
    assign drop    = v3 & full & ~pop;

    always_ff @(posedge clk10m or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            cnt      <= 3'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            unique case ({push_ok, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk10m) begin
        if (push_ok) begin
            mem[wr_ptr] <= {bub_q, sum};
        end
    end

    assign code_valid  = (cnt != 3'd0);
    // Gated so the outputs read zero while empty or in reset.
    assign code        = code_valid ? mem[rd_ptr][CODE_W-1:0] : '0;
    assign code_bubble = code_valid & mem[rd_ptr][CODE_W];

endmodule

// File: tb/tb_tdc_therm_enc.sv
// Scoreboard bench for tdc_therm_enc: directed vectors push expected
// words into a queue, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_tdc_therm_enc;

    localparam int TAPS   = 256;
    localparam int CODE_W = 9;

    logic              clk10m = 1'b0;
    logic              rst = 1'b1;
    logic              smp_valid = 1'b0;
    logic [TAPS-1:0]   smp_taps = '0;
    logic              code_valid;
    logic              code_ready = 1'b0;
    logic [CODE_W-1:0] code;
    logic              code_bubble;
    logic [7:0]        drop_cnt;

    int tests   = 0;
    int fails   = 0;
    int pop_cnt = 0;
    int p0;
    logic [TAPS-1:0] v;
    logic [CODE_W:0] exp_q [$];

    tdc_therm_enc #(.TAPS(TAPS), .CODE_W(CODE_W)) dut (
        .clk10m      (clk10m),
        .rst         (rst),
        .smp_valid   (smp_valid),
        .smp_taps    (smp_taps),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .code        (code),
        .code_bubble (code_bubble),
        .drop_cnt    (drop_cnt)
    );

    always #50 clk10m = ~clk10m;

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, exp);
        end
    endtask

    function automatic logic [TAPS-1:0] therm(input int n);
        logic [TAPS-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk10m);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(
        input logic [TAPS-1:0] t,
        input int              c,
        input logic            b,
        input logic            keep
    );
        smp_valid = 1'b1;
        smp_taps  = t;
        if (keep) begin
            exp_q.push_back({b, CODE_W'(c)});
        end
        tick();
        smp_valid = 1'b0;
    endtask

    always @(negedge clk10m) begin
        if (!rst && code_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_word: got code %0d, expected none",
                         code);
            end else begin
                check("code", code, exp_q[0][CODE_W-1:0]);
                check("bubble", code_bubble, exp_q[0][CODE_W]);
                if (code_ready) begin
                    void'(exp_q.pop_front());
                    pop_cnt++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("rst_valid", code_valid, 0);
        check("rst_code", code, 0);
        check("rst_bubble", code_bubble, 0);
        check("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        code_ready = 1'b1;
        idle(2);

        send(therm(100), 100, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk10m);
            check($sformatf("lat_k%0d", k), code_valid, 32'(k == 4));
        end
        idle(3);

        send('0, 0, 1'b0, 1'b1);
        send('1, 256, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk10m);
            check($sformatf("ext_k%0d", k), code_valid,
                  32'(k == 3 || k == 4));
        end
        idle(3);

        v = therm(100); v[50] = 1'b0;
        send(v, 100, 1'b0, 1'b1);
        v = therm(100); v[50] = 1'b0; v[51] = 1'b0;
        send(v, 98, 1'b1, 1'b1);
        v = therm(100); v[0] = 1'b0;
        send(v, 100, 1'b0, 1'b1);
        v = therm(100); v[150] = 1'b1;
        send(v, 100, 1'b0, 1'b1);
        v = therm(100); v[150] = 1'b1; v[151] = 1'b1;
        send(v, 102, 1'b1, 1'b1);
        send(therm(255), 255, 1'b0, 1'b1);
        v = '0; v[255] = 1'b1;
        send(v, 0, 1'b0, 1'b1);
        idle(8);
        check("bub_drained", exp_q.size(), 0);
        check("bub_drop", drop_cnt, 0);

        code_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(therm(10 * (i + 1)), 10 * (i + 1), 1'b0, i < 4);
        end
        idle(6);
        check("bp_drop", drop_cnt, 3);
        check("bp_held", code_valid, 1);
        code_ready = 1'b1;
        idle(6);
        check("bp_drained", exp_q.size(), 0);
        check("bp_empty", code_valid, 0);

        code_ready = 1'b0;
        p0 = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 7) begin
                code_ready = 1'b1;
                p0 = pop_cnt;
            end
            send(therm(20 + i * 7), 20 + i * 7, 1'b0, 1'b1);
        end
        repeat (7) @(negedge clk10m);
        #1;
        check("full_tput", pop_cnt - p0, 12);
        check("full_drop", drop_cnt, 3);
        check("full_drained", exp_q.size(), 0);
        idle(3);

        code_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(therm(30 + i), 30 + i, 1'b0, 1'b1);
        end
        idle(1);
        check("pre_rst_valid", code_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", code_valid, 0);
        check("mid_rst_code", code, 0);
        check("mid_rst_bubble", code_bubble, 0);
        check("mid_rst_drop", drop_cnt, 0);
        exp_q.delete();
        idle(2);
        p0 = pop_cnt;
        rst = 1'b0;
        send(therm(77), 77, 1'b0, 1'b1);
        code_ready = 1'b1;
        idle(10);
        check("post_rst_words", pop_cnt - p0, 1);
        check("post_rst_drained", exp_q.size(), 0);
        check("post_rst_drop", drop_cnt, 0);
        check("post_rst_empty", code_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
